// File: rtl/range_ascii_formatter.sv
// Range-reading to ASCII formatter.
//
// Converts an unsigned binary range (cm) into four ASCII digits for the downstream 4-digit
// 7-segment display driver. Conversion is iterative double-dabble, one input bit per clock:
//   IDLE --START--> SHIFT (WIDTH edges) --> FORMAT (1 edge, DONE pulse) --> IDLE
// Readings above MAX_VALUE skip SHIFT and format as "----" with OVF set.
//
// Build option:
//   RANGE_ASCII_LZB_EN  when defined, leading zeros are blanked to spaces (units never blanked),
//                       and the reset pattern becomes "   0". Default is zero padding ("0042").
//
// DATA1..DATA4 and OVF only change on the FORMAT edge or reset, so the display driver may
// sample them at any time.

module range_ascii_formatter #(
  parameter int unsigned WIDTH     = 14,   // legal range 4..16
  parameter int unsigned MAX_VALUE = 9999
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] VALUE,
  input  logic             START,
  output logic [7:0]       DATA1,
  output logic [7:0]       DATA2,
  output logic [7:0]       DATA3,
  output logic [7:0]       DATA4,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF
);

  localparam logic [7:0] CharZero  = 8'h30;
  localparam logic [7:0] CharDash  = 8'h2D;
  localparam logic [7:0] CharSpace = 8'h20;
  localparam logic [3:0] LastCnt   = 4'(WIDTH - 1);

`ifdef RANGE_ASCII_LZB_EN
  localparam logic [7:0] RstCharHi = CharSpace;
`else
  localparam logic [7:0] RstCharHi = CharZero;
`endif
  // Units digit always shows a character, blanked or not.
  localparam logic [7:0] RstCharLo = CharZero;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StFormat = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ovf_flag_q, ovf_flag_d;

  logic [7:0]       data1_q, data1_d;
  logic [7:0]       data2_q, data2_d;
  logic [7:0]       data3_q, data3_d;
  logic [7:0]       data4_q, data4_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [15:0]      bcd_adj;
  logic             value_over;
  logic [7:0]       fmt1, fmt2, fmt3, fmt4;

  // Out-of-range check done at the accepting edge so overflow never enters SHIFT.
  always_comb begin
    value_over = 32'(VALUE) > 32'(MAX_VALUE);
  end

  // Shift/add-3 correction: every BCD nibble >= 5 gets +3 before the next shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Character mapping of the finished BCD value, including overflow and optional blanking.
  always_comb begin
    fmt1 = CharZero + {4'h0, bcd_q[15:12]};
    fmt2 = CharZero + {4'h0, bcd_q[11:8]};
    fmt3 = CharZero + {4'h0, bcd_q[7:4]};
    fmt4 = CharZero + {4'h0, bcd_q[3:0]};
`ifdef RANGE_ASCII_LZB_EN
    // Blank from the left until the first nonzero digit; units stays visible.
    if (bcd_q[15:12] == 4'd0) begin
      fmt1 = CharSpace;
      if (bcd_q[11:8] == 4'd0) begin
        fmt2 = CharSpace;
        if (bcd_q[7:4] == 4'd0) begin
          fmt3 = CharSpace;
        end
      end
    end
`endif
    if (ovf_flag_q) begin
      fmt1 = CharDash;
      fmt2 = CharDash;
      fmt3 = CharDash;
      fmt4 = CharDash;
    end
  end

  // Next-state and registered-output logic for the IDLE/SHIFT/FORMAT sequencer.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    data3_d    = data3_q;
    data4_d    = data4_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          sr_d       = VALUE;
          bcd_d      = '0;
          cnt_d      = LastCnt;
          busy_d     = 1'b1;
          ovf_flag_d = value_over;
          state_d    = value_over ? StFormat : StShift;
        end
      end

      StShift: begin
        // {BCD, shift register} moves left one bit; input MSB enters the BCD LSB.
        {bcd_d, sr_d} = {bcd_adj[14:0], sr_q, 1'b0};
        if (cnt_q == 4'd0) begin
          state_d = StFormat;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StFormat: begin
        data1_d = fmt1;
        data2_d = fmt2;
        data3_d = fmt3;
        data4_d = fmt4;
        ovf_d   = ovf_flag_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      data1_q    <= RstCharHi;
      data2_q    <= RstCharHi;
      data3_q    <= RstCharHi;
      data4_q    <= RstCharLo;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      data3_q    <= data3_d;
      data4_q    <= data4_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign DATA1 = data1_q;
  assign DATA2 = data2_q;
  assign DATA3 = data3_q;
  assign DATA4 = data4_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign OVF   = ovf_q;

endmodule

// File: doc/range_ascii_formatter.md
Name: range_ascii_formatter

Overview:
- Converts an unsigned binary range reading (cm) into four ASCII digit characters for the 4-digit 7-segment display driver, which sits directly downstream.
- Uses an iterative double-dabble (shift/add-3) converter, one input bit per clock.
- Has a START/BUSY/DONE handshake. DATA1..DATA4 hold the last completed result until the next conversion finishes.

Parameters:
- WIDTH, 14, width of VALUE in bits; legal range 4..16. The BCD accumulator is always 16 bits (4 digits).
- MAX_VALUE, 9999, largest value displayed. Any larger VALUE is an overflow.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- VALUE  input  WIDTH  unsigned binary reading; sampled only on the accepting edge.
- START  input  1  request a conversion; honoured only in IDLE.
- DATA1  output  8  ASCII thousands digit (leftmost display digit).
- DATA2  output  8  ASCII hundreds digit.
- DATA3  output  8  ASCII tens digit.
- DATA4  output  8  ASCII units digit (rightmost display digit).
- BUSY  output  1  high from the accepting edge until the result edge.
- DONE  output  1  one-cycle pulse when DATA1..DATA4 and OVF update.
- OVF  output  1  last accepted VALUE exceeded MAX_VALUE.

Behaviour:
- Reset (RST_N low, asynchronous) forces:
  - state IDLE; BUSY=0, DONE=0, OVF=0;
  - DATA1..DATA4 = "0" (8'h30) each, or the blanked pattern under the optional feature.
  - Internal shift register, BCD accumulator and bit counter cleared.
- Reset mid-conversion aborts the conversion: no DONE is produced and the partial result is discarded.
- States: IDLE, SHIFT, FORMAT.
- IDLE, START=1 at edge k:
  - latch VALUE into the shift register; clear the BCD accumulator; bit counter = WIDTH-1; BUSY=1.
  - If VALUE > MAX_VALUE: set internal overflow flag and go to FORMAT.
  - Otherwise go to SHIFT.
- IDLE, START=0: no change; DONE=0.
- SHIFT, each edge:
  - for each BCD nibble >= 5, add 3 (all four nibbles evaluated in parallel, combinationally, before the shift);
  - then shift {BCD, shift register} left one bit; decrement the counter.
  - After the WIDTH-th shift (counter was 0), go to FORMAT.
- FORMAT, one edge:
  - DATAn = 8'h30 + nibble, with DATA1 = the most significant nibble.
  - If overflow: all four DATAn = "-" (8'h2D) and OVF=1; otherwise OVF=0.
  - DONE=1 for exactly one cycle; BUSY=0; return to IDLE.
- Latency, START accepted at edge k:
  - normal: result and DONE visible after edge k+WIDTH+1 (k+15 for default WIDTH).
  - overflow: after edge k+1.
- Throughput: START is ignored in SHIFT and FORMAT, including the FORMAT edge itself. The earliest next accept is edge k+WIDTH+2.
  - START held high continuously therefore converts every WIDTH+2 cycles.
- VALUE changes while BUSY have no effect on the current conversion.
- DATA1..DATA4 and OVF change only on the FORMAT edge (or reset). They are stable otherwise, so the display driver may sample them at any time.
- Nibbles never exceed 9 for VALUE <= 9999, so no out-of-range character is produced.
- All outputs are registered.

Optional Feature:
- Macro: RANGE_ASCII_LZB_EN.
- Defined: leading-zero blanking.
  - In FORMAT, scan from DATA1: each leading "0" digit becomes space (8'h20) until the first nonzero digit.
  - DATA4 is never blanked.
  - Reset value is "   0".
  - Overflow output "----" is unaffected.
- Undefined: zero-padded output (e.g. "0042"); reset value "0000".

Test Plan:
1. Assert RST_N=0, then release → DATA1..DATA4 = "0000" ("   0" with LZB); BUSY=0, DONE=0, OVF=0.
2. VALUE=1234, 1-cycle START at edge k → BUSY high for edges k..k+14; DONE pulses after edge k+15 for exactly one cycle; DATA = "1","2","3","4"; OVF=0.
3. Boundary values, one conversion each:
   - VALUE=9999 → "9999".
   - VALUE=0 → "0000" / "   0" with LZB.
   - VALUE=40 → "0040" / "  40" with LZB.
   - VALUE=105 with LZB → " 105".
4. VALUE=10000 → DONE one cycle after acceptance; DATA = "----"; OVF=1. Then VALUE=7 → "0007"; OVF=0.
5. START held high; VALUE set to 321 at accept, then changed to 999 on the next cycle → first result "0321". Second accept occurs 16 edges after the first and yields "0999". DONE pulses are 16 cycles apart.
6. Drive RST_N low on the 7th SHIFT cycle of a VALUE=5555 conversion → outputs return to reset values immediately; no DONE. After release, START with VALUE=88 → "0088" with normal latency.
